// File: rtl/tick_pkg.sv
// Shared types and default widths for the tick sequencer.
// The optional burst feature is enabled by defining TICK_CTRL_BURST_EN.
package tick_pkg;
  localparam int TICK_CNT_W   = 16;
  localparam int TICK_BURST_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } tick_state_t;
endpackage

// File: rtl/tick_counter.sv
// Modulo counter: counts 0..max on inc, wrap flags the terminal value.
// clr has priority over inc.
module tick_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] max,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wrap = (cnt_q == max);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/tick_ctrl.sv
// Programmable tick sequencer: FSM, period/burst latches and registered outputs.
// Define TICK_CTRL_BURST_EN to bound the sequence to burst_len ticks with a done pulse.
module tick_ctrl
  import tick_pkg::*;
#(
  parameter int CNT_W   = TICK_CNT_W,
  parameter int BURST_W = TICK_BURST_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               en,
  input  logic [CNT_W-1:0]   period,
  input  logic [BURST_W-1:0] burst_len,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   cnt
);
  tick_state_t      state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             count_en, cnt_clr, wrap, tick_fire, burst_last;
  logic [CNT_W-1:0] per_max;

  // PAUSE with en high counts on the resuming edge, so a pause costs exactly its length.
  assign count_en  = ((state_q == RUN) || (state_q == PAUSE)) && en && !stop;
  assign cnt_clr   = stop || (state_q == IDLE) || (state_q == DONE);
  assign tick_fire = count_en && wrap;
  assign per_max   = per_q - CNT_W'(1);

  tick_counter #(.CNT_W(CNT_W)) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (count_en),
    .max   (per_max),
    .cnt   (cnt),
    .wrap  (wrap)
  );

`ifdef TICK_CTRL_BURST_EN
  logic [BURST_W-1:0] blen_q, blen_d, bcnt_q, bcnt_d;

  always_comb begin
    blen_d = blen_q;
    bcnt_d = bcnt_q;
    if (state_q == IDLE) begin
      bcnt_d = '0;
      if (start && !stop) blen_d = burst_len;
    end else if (tick_fire) begin
      bcnt_d = bcnt_q + BURST_W'(1);
    end
  end

  assign burst_last = (blen_q != '0) && ((bcnt_q + BURST_W'(1)) == blen_q);
  assign done_d     = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      blen_q <= '0;
      bcnt_q <= '0;
    end else begin
      blen_q <= blen_d;
      bcnt_q <= bcnt_d;
    end
  end
`else
  logic unused_burst_len;
  assign unused_burst_len = ^burst_len;
  assign burst_last       = 1'b0;
  assign done_d           = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    tick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          per_d   = (period == '0) ? CNT_W'(1) : period;
        end
      end
      RUN, PAUSE: begin
        state_d = en ? RUN : PAUSE;
        if (tick_fire) begin
          tick_d = 1'b1;
          if (burst_last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (stop) state_d = IDLE;
    // busy stays high through the cycle that carries the done pulse
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      per_q   <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tick = tick_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_tick_ctrl.sv
// Self-checking bench for tick_ctrl: directed scenarios then random traffic,
// every cycle compared against a count-based reference model.
module tb_tick_ctrl;
`ifdef TICK_CTRL_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, stop, en;
  logic [15:0] period;
  logic [7:0]  burst_len;
  logic        tick, busy, done;
  logic [15:0] cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int ticks_obs;

  // reference model: running flag, enabled cycles counted mod P, ticks issued
  int m_active = 0, m_fin = 0, m_n = 0, m_p = 1, m_len = 0, m_iss = 0;
  bit e_tick, e_busy, e_done;

  tick_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .en        (en),
    .period    (period),
    .burst_len (burst_len),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .cnt       (cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input bit s, input bit sp, input bit e, input int per, input int bl,
                      input bit r, input string tag);
    start = s; stop = sp; en = e; period = 16'(per); burst_len = 8'(bl); reset = r;
    @(posedge clk);
    e_tick = 1'b0;
    e_done = 1'b0;
    if (r) begin
      m_active = 0; m_fin = 0; m_n = 0; e_busy = 1'b0;
    end else begin
      e_done = (m_fin != 0);
      if (m_fin != 0) begin
        m_fin = 0; m_n = 0; e_busy = 1'b1;
      end else if (sp) begin
        m_active = 0; m_n = 0; e_busy = 1'b0;
      end else if (m_active == 0) begin
        if (s) begin
          m_active = 1; m_p = (per == 0) ? 1 : per; m_len = bl; m_iss = 0; m_n = 0;
        end
        e_busy = (m_active != 0);
      end else begin
        if (e) begin
          m_n = m_n + 1;
          if (m_n == m_p) begin
            m_n = 0; e_tick = 1'b1; m_iss = m_iss + 1;
            if (BURST_ON && m_len != 0 && m_iss == m_len) begin
              m_active = 0; m_fin = 1;
            end
          end
        end
        e_busy = 1'b1;
      end
    end
    #1;
    n_cmp++;
    assert (tick === e_tick) else begin
      n_fail++; $error("FAIL %s tick: got %b want %b", tag, tick, e_tick);
    end
    n_cmp++;
    assert (busy === e_busy) else begin
      n_fail++; $error("FAIL %s busy: got %b want %b", tag, busy, e_busy);
    end
    n_cmp++;
    assert (done === e_done) else begin
      n_fail++; $error("FAIL %s done: got %b want %b", tag, done, e_done);
    end
    n_cmp++;
    assert (cnt === 16'(m_n)) else begin
      n_fail++; $error("FAIL %s cnt: got %0d want %0d", tag, cnt, m_n);
    end
    if (tick === 1'b1) ticks_obs++;
  endtask

  initial begin
    start = 0; stop = 0; en = 0; period = 0; burst_len = 0; reset = 1;

    // reset state
    repeat (3) step(0, 0, 0, 0, 0, 1, "reset");
    step(0, 0, 1, 4, 0, 0, "idle");

    // 1: period 4 free-running, ticks at 4, 8, 12
    step(1, 0, 1, 4, 0, 0, "t1_start");
    ticks_obs = 0;
    for (int i = 0; i < 12; i++) step(0, 0, 1, 4, 0, 0, "t1_run");
    n_cmp++;
    assert (ticks_obs === 3) else begin
      n_fail++; $error("FAIL t1_tick_count: got %0d want 3", ticks_obs);
    end
    // start and period change while busy are ignored
    step(1, 0, 1, 2, 0, 0, "t1_restart_ignored");
    step(0, 0, 1, 2, 0, 0, "t1_run2");
    step(0, 1, 1, 4, 0, 0, "t1_stop");

    // 2: en low 3 cycles mid-count delays the next tick by 3
    step(1, 0, 1, 4, 0, 0, "t2_start");
    step(0, 0, 1, 4, 0, 0, "t2_run");
    step(0, 0, 1, 4, 0, 0, "t2_run");
    repeat (3) step(0, 0, 0, 4, 0, 0, "t2_pause");
    repeat (6) step(0, 0, 1, 4, 0, 0, "t2_resume");

    // 3: stop at cnt=3 beats the wrap
    step(0, 1, 1, 4, 0, 0, "t3_stop_prev");
    step(1, 0, 1, 4, 0, 0, "t3_start");
    repeat (3) step(0, 0, 1, 4, 0, 0, "t3_run");
    step(0, 1, 1, 4, 0, 0, "t3_stop");
    step(0, 0, 1, 4, 0, 0, "t3_idle");

    // stop and start together in IDLE: stays idle
    step(1, 1, 1, 4, 0, 0, "start_stop");

    // 4: period 0 behaves as 1
    step(1, 0, 1, 0, 0, 0, "t4_start");
    repeat (5) step(0, 0, 1, 0, 0, 0, "t4_run");
    step(0, 0, 0, 0, 0, 0, "t4_pause");
    step(0, 0, 1, 0, 0, 0, "t4_resume");
    step(0, 1, 1, 0, 0, 0, "t4_stop");

    // 5: burst of 3 with period 2 (unbounded in the default build)
    step(1, 0, 1, 2, 3, 0, "t5_start");
    repeat (9) step(0, 0, 1, 2, 3, 0, "t5_run");
    step(0, 1, 1, 2, 3, 0, "t5_stop");
    // stop landing on the done cycle
    step(1, 0, 1, 1, 1, 0, "t5b_start");
    step(0, 0, 1, 1, 1, 0, "t5b_run");
    step(0, 1, 1, 1, 1, 0, "t5b_stop");
    step(0, 1, 1, 1, 1, 0, "t5b_idle");

    // 6: reset mid-run, then restart
    step(1, 0, 1, 3, 0, 0, "t6_start");
    repeat (4) step(0, 0, 1, 3, 0, 0, "t6_run");
    step(0, 0, 1, 3, 0, 1, "t6_reset");
    step(1, 0, 1, 3, 0, 0, "t6_restart");
    repeat (6) step(0, 0, 1, 3, 0, 0, "t6_run2");
    step(0, 1, 0, 3, 0, 0, "t6_stop");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 80), int'($urandom_range(0, 5)),
           int'($urandom_range(0, 4)), ($urandom_range(0, 199) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
